// File: rtl/issue_pkg.sv
// Shared constants for the issue-select slice.
// Holds the default sizing of the issue queue and ports, the port-number map
// and a small helper used to size the multiplier busy counter.
package issue_pkg;

    localparam int unsigned DEF_ISQ_DEPTH = 64;
    localparam int unsigned DEF_IDX_W     = 6;
    localparam int unsigned DEF_NUM_PORTS = 4;
    localparam int unsigned DEF_INST_W    = 66;
    localparam int unsigned DEF_MUL_II    = 2;

    // Issue port numbering; port 0 is the only multiplier-capable port.
    typedef enum logic [1:0] {
        MUL  = 2'd0,
        ALU1 = 2'd1,
        ALU2 = 2'd2,
        ADR  = 2'd3
    } port_e;

    // Bits needed to hold a count of ii-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned ii);
        return (ii > 1) ? $clog2(ii) : 1;
    endfunction

endpackage

// File: rtl/issue_sel_rr_pick.sv
// rr_pick: rotating-priority one-hot picker.
// Scans req upward starting at ptr, wrapping from DEPTH-1 to 0, and returns
// the first set request.
//   req      in   DEPTH  request vector
//   ptr      in   IDX_W  index with highest priority
//   gnt_c    out  DEPTH  one-hot grant (zero when nothing requested)
//   idx_c    out  IDX_W  index of the granted request
//   found_c  out  1      a request was granted
module rr_pick
    import issue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_ISQ_DEPTH,
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic [DEPTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [DEPTH-1:0] gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             found_c
);

    logic [IDX_W-1:0] cand;

    // First requester at or after ptr, modulo DEPTH.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cand = IDX_W'((32'(ptr) + i) % DEPTH);
            if (!found_c && req[cand]) begin
                found_c     = 1'b1;
                gnt_c[cand] = 1'b1;
                idx_c       = cand;
            end
        end
    end

endmodule

// File: rtl/issue_sel.sv
// issue_sel: per-cycle issue selection from the issue queue onto NUM_PORTS
// ports. Ports select in ascending order; an entry taken by a lower port is
// hidden from higher ports. Port 0 feeds a multiplier with initiation
// interval MUL_II and is blocked while its busy counter is non-zero.
// Optional macro ISSUE_SEL_RR_EN: per-port round-robin priority pointers;
// without it every port uses fixed lowest-index priority.
//   clk, rst       clock, synchronous active-high reset
//   flush          drop all issue valids and grants, clear multiplier busy
//   ent_rdy        per-entry ready
//   ent_fu_mask    bit [e*NUM_PORTS+p]: entry e may issue on port p
//   ent_data       flat entry packets
//   port_stall     per-port downstream stall (holds that port's outputs)
//   iss_vld/iss_data/iss_idx  registered issue outputs per port
//   clr_wat        combinational OR of this cycle's grant one-hots
module issue_sel
    import issue_pkg::*;
#(
    parameter int unsigned ISQ_DEPTH = DEF_ISQ_DEPTH,
    parameter int unsigned IDX_W     = DEF_IDX_W,
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned INST_W    = DEF_INST_W,
    parameter int unsigned MUL_II    = DEF_MUL_II
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [ISQ_DEPTH-1:0]           ent_rdy,
    input  logic [ISQ_DEPTH*NUM_PORTS-1:0] ent_fu_mask,
    input  logic [ISQ_DEPTH*INST_W-1:0]    ent_data,
    input  logic [NUM_PORTS-1:0]           port_stall,
    output logic [NUM_PORTS-1:0]           iss_vld,
    output logic [NUM_PORTS*INST_W-1:0]    iss_data,
    output logic [NUM_PORTS*IDX_W-1:0]     iss_idx,
    output logic [ISQ_DEPTH-1:0]           clr_wat
);

    localparam int unsigned BUSY_W = cnt_w(MUL_II);

    logic [BUSY_W-1:0]           busy_q;
    logic [NUM_PORTS-1:0]        found_c;
    logic [NUM_PORTS*IDX_W-1:0]  gnt_idx_c;
    logic [NUM_PORTS*INST_W-1:0] gnt_data_c;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic                 ok_c;
        logic [ISQ_DEPTH-1:0] prev_c;
        logic [ISQ_DEPTH-1:0] req_c;
        logic [ISQ_DEPTH-1:0] gnt_c;
        logic [ISQ_DEPTH-1:0] taken_c;
        logic [IDX_W-1:0]     ptr;
        logic [IDX_W-1:0]     idx_c;
        logic                 fnd_c;

        // Entries already granted to lower-numbered ports this cycle.
        if (p == 0) begin : g_first
            assign prev_c = '0;
        end else begin : g_next
            assign prev_c = g_port[p-1].taken_c;
        end

        // Port may grant only when not stalled, not flushing, not in reset
        // and, for the multiplier port, not inside the initiation interval.
        assign ok_c = !rst && !flush && !port_stall[p] &&
                      ((p != int'(MUL)) || (busy_q == '0));

        always_comb begin
            req_c = '0;
            for (int unsigned e = 0; e < ISQ_DEPTH; e++) begin
                req_c[e] = ok_c && ent_rdy[e] && ent_fu_mask[e*NUM_PORTS+p] && !prev_c[e];
            end
        end

        rr_pick #(
            .DEPTH (ISQ_DEPTH),
            .IDX_W (IDX_W)
        ) u_pick (
            .req     (req_c),
            .ptr     (ptr),
            .gnt_c   (gnt_c),
            .idx_c   (idx_c),
            .found_c (fnd_c)
        );

        assign taken_c                          = prev_c | gnt_c;
        assign found_c[p]                       = fnd_c;
        assign gnt_idx_c[p*IDX_W +: IDX_W]      = idx_c;
        assign gnt_data_c[p*INST_W +: INST_W]   = ent_data[32'(idx_c)*INST_W +: INST_W];

`ifdef ISSUE_SEL_RR_EN
        // Next search starts just past the last granted entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr <= '0;
            end else if (fnd_c) begin
                ptr <= (idx_c == IDX_W'(ISQ_DEPTH-1)) ? '0 : idx_c + IDX_W'(1);
            end
        end
`else
        assign ptr = '0;
`endif
    end

    assign clr_wat = g_port[NUM_PORTS-1].taken_c;

    // Issue registers and multiplier busy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld  <= '0;
            iss_data <= '0;
            iss_idx  <= '0;
            busy_q   <= '0;
        end else begin
            if (flush) begin
                busy_q <= '0;
            end else if (found_c[int'(MUL)]) begin
                busy_q <= BUSY_W'(MUL_II-1);
            end else if (busy_q != '0) begin
                busy_q <= busy_q - BUSY_W'(1);
            end

            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (flush) begin
                    iss_vld[p] <= 1'b0;
                end else if (!port_stall[p]) begin
                    iss_vld[p] <= found_c[p];
                end
                // Grants only occur on non-stalled, non-flushed ports.
                if (found_c[p]) begin
                    iss_data[p*INST_W +: INST_W] <= gnt_data_c[p*INST_W +: INST_W];
                    iss_idx[p*IDX_W +: IDX_W]    <= gnt_idx_c[p*IDX_W +: IDX_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_sel.sv
// Directed bench for issue_sel at default parameters (64 entries, 4 ports,
// 66-bit packets, MUL_II=2). Works with or without ISSUE_SEL_RR_EN.
module tb_issue_sel;
    import issue_pkg::*;

    localparam int unsigned D  = 64;
    localparam int unsigned IW = 6;
    localparam int unsigned NP = 4;
    localparam int unsigned W  = 66;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [D-1:0]    ent_rdy;
    logic [D*NP-1:0] ent_fu_mask;
    logic [D*W-1:0]  ent_data;
    logic [NP-1:0]   port_stall;
    logic [NP-1:0]   iss_vld;
    logic [NP*W-1:0] iss_data;
    logic [NP*IW-1:0] iss_idx;
    logic [D-1:0]    clr_wat;

    issue_sel #(
        .ISQ_DEPTH (D),
        .IDX_W     (IW),
        .NUM_PORTS (NP),
        .INST_W    (W),
        .MUL_II    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ent_rdy     (ent_rdy),
        .ent_fu_mask (ent_fu_mask),
        .ent_data    (ent_data),
        .port_stall  (port_stall),
        .iss_vld     (iss_vld),
        .iss_data    (iss_data),
        .iss_idx     (iss_idx),
        .clr_wat     (clr_wat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [D-1:0]    rdy;
        logic [D*NP-1:0] mask;
        logic [NP-1:0]   stall;
        logic            flush;
        logic [D-1:0]    exp_clr;
        logic [NP-1:0]   exp_vld;
        logic [NP*IW-1:0] exp_idx;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [W-1:0] data_of(input int e);
        return {2'(e), 32'hC0DE_0000 + 32'(e), ~32'(e)};
    endfunction

    function automatic logic [D-1:0] rb(input int e);
        return 64'(1) << e;
    endfunction

    function automatic logic [D*NP-1:0] fm(input int e, input logic [NP-1:0] p);
        return (256'(p)) << (e*NP);
    endfunction

    function automatic logic [NP*IW-1:0] ix(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic vec_t mk(input logic [D-1:0] r, input logic [D*NP-1:0] m,
                                input logic [NP-1:0] s, input logic f,
                                input logic [D-1:0] c, input logic [NP-1:0] v,
                                input logic [NP*IW-1:0] x);
        vec_t t;
        t.rdy = r; t.mask = m; t.stall = s; t.flush = f;
        t.exp_clr = c; t.exp_vld = v; t.exp_idx = x;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [D-1:0] r, input logic [D*NP-1:0] m,
                         input logic [NP-1:0] s, input logic f);
        ent_rdy = r; ent_fu_mask = m; port_stall = s; flush = f;
    endtask

    // Check combinational clr_wat mid-cycle, then advance past the edge.
    task automatic step(input string name, input logic [D-1:0] exp_clr);
        @(negedge clk);
        chk(name, clr_wat, exp_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('0, '0, '0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [IW-1:0] idx_at(input int p);
        return iss_idx[p*IW +: IW];
    endfunction

    function automatic logic [W-1:0] data_at(input int p);
        return iss_data[p*W +: W];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NP*IW-1:0] xv;
        logic [IW-1:0]    xi;
        int               exp_e;

        for (int e = 0; e < int'(D); e++) ent_data[e*W +: W] = data_of(e);

        tbl[0] = mk('0, '0, '0, 1'b0, '0, 4'b0000, ix(0,0,0,0));
        tbl[1] = mk(rb(3)|rb(5), fm(3,4'b0110)|fm(5,4'b0110), '0, 1'b0,
                    64'h28, 4'b0110, ix(0,3,5,0));
        tbl[2] = mk(rb(7)|rb(10), fm(7,4'b1000)|fm(10,4'b1110), '0, 1'b0,
                    rb(7)|rb(10), 4'b1010, ix(0,10,0,7));
        tbl[3] = mk(rb(4)|rb(6), fm(4,4'b1111)|fm(6,4'b0101), '0, 1'b0,
                    rb(4)|rb(6), 4'b0101, ix(4,0,6,0));
        tbl[4] = mk(rb(4)|rb(6), fm(4,4'b1111)|fm(6,4'b0101), '0, 1'b0,
                    rb(4)|rb(6), 4'b0110, ix(0,4,6,0));
        tbl[5] = mk(rb(4), fm(4,4'b1111), 4'b0110, 1'b0,
                    rb(4), 4'b0111, ix(4,4,6,0));
        tbl[6] = mk('1, '1, '0, 1'b1, '0, 4'b0000, ix(0,0,0,0));
        tbl[7] = mk(rb(0), fm(0,4'b0001), '0, 1'b0, rb(0), 4'b0001, ix(0,0,0,0));
        tbl[8] = mk(rb(62)|rb(63), fm(62,4'b1000)|fm(63,4'b1010), '0, 1'b0,
                    rb(62)|rb(63), 4'b1010, ix(0,63,0,62));

        // Reset together with flush and every entry ready.
        rst = 1'b1;
        apply('1, '1, '0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_clr", clr_wat, '0);
        @(posedge clk); #1;
        chk("rst_vld", iss_vld, '0);
        chk("rst_idx", iss_idx, '0);
        chk("rst_data_lo", iss_data[127:0], '0);
        chk("rst_data_hi", iss_data[NP*W-1:128], '0);
        rst = 1'b0;
        apply('0, '0, '0, 1'b0);

        // Idle after reset.
        for (int k = 0; k < 10; k++) begin
            step($sformatf("idle%0d_clr", k), '0);
            chk($sformatf("idle%0d_vld", k), iss_vld, '0);
        end

        // Table vectors, applied back to back (state carries between them).
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].rdy, tbl[i].mask, tbl[i].stall, tbl[i].flush);
            step($sformatf("vec%0d_clr", i), tbl[i].exp_clr);
            chk($sformatf("vec%0d_vld", i), iss_vld, tbl[i].exp_vld);
            xv = tbl[i].exp_idx;
            for (int p = 0; p < int'(NP); p++) begin
                if (tbl[i].exp_vld[p]) begin
                    xi = xv[p*IW +: IW];
                    chk($sformatf("vec%0d_idx%0d", i, p), idx_at(p), xi);
                    chk($sformatf("vec%0d_data%0d", i, p), data_at(p), data_of(int'(xi)));
                end
            end
        end

        // Multiplier initiation interval: issue 0, one idle cycle, issue 1.
        do_reset();
        apply(rb(0)|rb(1), fm(0,4'b0001)|fm(1,4'b0001), '0, 1'b0);
        step("mul_t1_clr", rb(0));
        chk("mul_t1_vld", iss_vld[0], 1'b1);
        chk("mul_t1_idx", idx_at(0), 6'd0);
        apply(rb(1), fm(1,4'b0001), '0, 1'b0);
        step("mul_t2_clr", '0);
        chk("mul_t2_vld", iss_vld[0], 1'b0);
        step("mul_t3_clr", rb(1));
        chk("mul_t3_vld", iss_vld[0], 1'b1);
        chk("mul_t3_idx", idx_at(0), 6'd1);

        // Stall on port 3 holds outputs and blocks the grant.
        do_reset();
        apply(rb(9), fm(9,4'b1000), '0, 1'b0);
        step("stall_s0_clr", rb(9));
        chk("stall_s0_idx", idx_at(3), 6'd9);
        apply(rb(7), fm(7,4'b1000), 4'b1000, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step($sformatf("stall_s%0d_clr", k), '0);
            chk($sformatf("stall_s%0d_vld", k), iss_vld[3], 1'b1);
            chk($sformatf("stall_s%0d_data", k), data_at(3), data_of(9));
            chk($sformatf("stall_s%0d_idx", k), idx_at(3), 6'd9);
        end
        apply(rb(7), fm(7,4'b1000), '0, 1'b0);
        step("stall_rel_clr", rb(7));
        chk("stall_rel_idx", idx_at(3), 6'd7);
        chk("stall_rel_data", data_at(3), data_of(7));

        // Fairness between entries 2 and 9 on port 3.
        do_reset();
        apply(rb(2)|rb(9), fm(2,4'b1000)|fm(9,4'b1000), '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
`ifdef ISSUE_SEL_RR_EN
            exp_e = (k % 2 == 0) ? 2 : 9;
`else
            exp_e = 2;
`endif
            step($sformatf("rr%0d_clr", k), rb(exp_e));
            chk($sformatf("rr%0d_idx", k), idx_at(3), 6'(exp_e));
        end

        // Flush inside the multiplier busy window, with port 3 stalled.
        do_reset();
        apply(rb(5)|rb(8), fm(5,4'b0001)|fm(8,4'b1000), '0, 1'b0);
        step("fl_e1_clr", rb(5)|rb(8));
        chk("fl_e1_vld", iss_vld, 4'b1001);
        apply(rb(5)|rb(8), fm(5,4'b0001)|fm(8,4'b1000), 4'b1000, 1'b1);
        step("fl_e2_clr", '0);
        chk("fl_e2_vld", iss_vld, 4'b0000);
        apply(rb(5), fm(5,4'b0001), '0, 1'b0);
        step("fl_e3_clr", rb(5));
        chk("fl_e3_vld", iss_vld, 4'b0001);
        chk("fl_e3_idx", idx_at(0), 6'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_sel.md
ISSUE_SEL -- requirements
Module: issue_sel

Interface
REQ-001 Parameter ISQ_DEPTH, default 64: issue-queue entries scanned per cycle.
REQ-002 Parameter IDX_W, default 6: entry index width, equal to clog2(ISQ_DEPTH).
REQ-003 Parameter NUM_PORTS, default 4: issue ports; port 0 is the multiplier port.
REQ-004 Parameter INST_W, default 66: issued-instruction packet width.
REQ-005 Parameter MUL_II, default 2: multiplier initiation interval in cycles, minimum 1.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 flush  in  1  pipeline flush (branch mispredict).
REQ-009 ent_rdy  in  ISQ_DEPTH  entry is valid, waiting and has all operands ready.
REQ-010 ent_fu_mask  in  ISQ_DEPTH*NUM_PORTS  bit [e*NUM_PORTS+p] means entry e may issue on port p.
REQ-011 ent_data  in  ISQ_DEPTH*INST_W  flat entry packets, already in issue format.
REQ-012 port_stall  in  NUM_PORTS  downstream RF stage cannot accept on port p.
REQ-013 iss_vld  out  NUM_PORTS  registered issue valid per port.
REQ-014 iss_data  out  NUM_PORTS*INST_W  registered issued packet per port.
REQ-015 iss_idx  out  NUM_PORTS*IDX_W  registered issued entry index per port.
REQ-016 clr_wat  out  ISQ_DEPTH  combinational one-hot-per-grant wait-clear, same cycle as selection.

Function
REQ-017 Port p SHALL be a candidate port only when port_stall[p]=0, flush=0 and, for p=0, the multiplier busy counter is 0.
REQ-018 Entry e SHALL be eligible on port p iff ent_rdy[e] and ent_fu_mask[e*NUM_PORTS+p].
REQ-019 Ports SHALL select in ascending port order, and an entry granted to a lower port SHALL be excluded from all higher ports in the same cycle (no double issue).
REQ-020 Each port SHALL grant the first eligible entry scanning upward from its priority pointer, wrapping from ISQ_DEPTH-1 to 0.
REQ-021 clr_wat SHALL be the OR of all grant one-hots in the current cycle; it SHALL be zero when no grants occur.
REQ-022 On a grant, iss_vld[p]<=1 and iss_data/iss_idx SHALL load the granted entry on the next edge (1-cycle latency).
REQ-023 A non-stalled port with no grant SHALL load iss_vld[p]<=0; iss_data is don't-care but SHALL hold its previous value.
REQ-024 A stalled port SHALL hold iss_vld, iss_data and iss_idx unchanged and SHALL make no grant.
REQ-025 A port-0 grant SHALL load the busy counter with MUL_II-1; the counter SHALL decrement to 0 each cycle and saturate at 0.
REQ-026 flush SHALL clear all iss_vld and the busy counter on the next edge and suppress all grants that cycle; priority pointers SHALL be kept.
REQ-027 When rst and flush are both asserted, rst SHALL take precedence.

Reset
REQ-028 On rst, iss_vld=0, iss_data=0, iss_idx=0, all priority pointers=0 and busy counter=0; clr_wat SHALL be 0 while rst=1.

Configuration
REQ-029 With macro ISSUE_SEL_RR_EN defined, each port's pointer SHALL advance to (granted index+1) mod ISQ_DEPTH after a grant and hold otherwise (round-robin fairness).
REQ-030 Without ISSUE_SEL_RR_EN, all pointers SHALL be the constant 0 (fixed lowest-index priority) and no pointer registers SHALL be built.

Structure
REQ-031 ISQ_DEPTH, IDX_W, NUM_PORTS, INST_W, MUL_II defaults and the port-number constants (MUL=0, ALU1=1, ALU2=2, ADR=3) SHALL live in the shared package issue_pkg.
REQ-032 One sub-module, rr_pick (rotating-priority one-hot picker: request vector + pointer -> grant one-hot + index + found), SHALL be instantiated once per port.

Verification
REQ-033 Reset, then ent_rdy=0 -> iss_vld=0000 and clr_wat=0 for 10 cycles.
REQ-034 Entries 3 and 5 are both eligible on ports 1 and 2 only -> port1 grants 3 and port2 grants 5; clr_wat=0x28; next cycle iss_idx[1]=3 and iss_idx[2]=5.
REQ-035 MUL_II=2; entries 0 and 1 are eligible on port 0 and held ready -> port 0 issues 0, is idle for 1 cycle, then issues 1.
REQ-036 port_stall[3]=1 with entry 7 eligible on port 3 -> iss_data[3] is held and clr_wat[7]=0; after the stall releases, 7 is granted in that cycle.
REQ-037 ISSUE_SEL_RR_EN defined; entries 2 and 9 are continuously eligible on port 3 -> grants alternate 2, 9, 2, 9; with the macro undefined the grant is always 2.
REQ-038 flush during a port-0 busy window -> all iss_vld=0 and busy=0 next cycle, and port 0 grants immediately in the following cycle.
